// File: rtl/pipe_stage_reg.sv
// Registered valid/ready pipeline stage with stall, flush and an optional
// skid entry so that in_ready can come straight from a flop.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);
    logic              main_v, skid_v;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              acc, deq;

    assign out_valid = main_v & ~stall & ~flush;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign acc       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

    // Main entry loads from input when it is free or being drained this
    // cycle; otherwise a drain promotes the skid entry (empty when SKID=0).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v    <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
        end else if (acc && (deq || !main_v)) begin
            main_v    <= 1'b1;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
        end else if (deq) begin
            main_v    <= skid_v;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = ~skid_v & ~stall & ~flush;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    skid_v    <= 1'b0;
                    skid_ctrl <= '0;
                    skid_data <= '0;
                end else if (flush) begin
                    skid_v <= 1'b0;
                end else if (acc && !deq && main_v) begin
                    skid_v    <= 1'b1;
                    skid_ctrl <= in_ctrl;
                    skid_data <= in_data;
                end else if (deq) begin
                    skid_v <= 1'b0;
                end
            end
        end else begin : g_noskid
            assign in_ready  = ~stall & ~flush & (~main_v | out_ready);
            assign skid_v    = 1'b0;
            assign skid_ctrl = '0;
            assign skid_data = '0;
        end
    endgenerate
endmodule
